// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: operation codes, flag bit
// positions and the operand-width legality check.
package alu_pkg;

    // Operation codes carried on the 3-bit op port
    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_NOT = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    // Bit positions inside the 4-bit flags vector {N, Z, C, V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Operand widths the datapath is built for; shift amounts rely on a power of two
    function automatic bit width_is_legal(input int w);
        return (w == 4) || (w == 8) || (w == 16) || (w == 32);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {N, Z, C, V} flags for one beat.
// Optional feature: define ALU_PIPE_SAT_EN to clamp ADD/SUB results on
// signed overflow instead of wrapping.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    localparam int SHAMT_W = $clog2(WIDTH);

    alu_op_e            op_e;
    logic [WIDTH-1:0]   and_bits;
    logic [WIDTH-1:0]   or_bits;
    logic [WIDTH-1:0]   xor_bits;
    logic [WIDTH-1:0]   not_bits;
    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [SHAMT_W-1:0] shamt;
    logic               add_ovf;
    logic               sub_ovf;
    logic [WIDTH-1:0]   y_next;
    logic               c_next;
    logic               v_next;

    assign op_e  = alu_op_e'(op);
    assign shamt = b[SHAMT_W-1:0];

    // Bitwise logic lanes, one per operand bit
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic_lane
        assign and_bits[gi] = a[gi] & b[gi];
        assign or_bits[gi]  = a[gi] | b[gi];
        assign xor_bits[gi] = a[gi] ^ b[gi];
        assign not_bits[gi] = ~a[gi];
    end

    // One extra bit on top catches carry-out / borrow
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} - {1'b0, b};

    // Signed overflow: result sign disagrees with what the operand signs allow
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);

    // Guard bits on each side of the shifter capture the last bit shifted
    // out; with a zero amount the guard bit stays 0, giving C = 0.
    assign shl_ext = {1'b0, a} << shamt;
    assign shr_ext = {a, 1'b0} >> shamt;

    // Result mux and flag generation
    always_comb begin
        y_next = '0;
        c_next = 1'b0;
        v_next = 1'b0;
        case (op_e)
            OP_AND: y_next = and_bits;
            OP_OR:  y_next = or_bits;
            OP_XOR: y_next = xor_bits;
            OP_NOT: y_next = not_bits;
            OP_ADD: begin
                y_next = add_ext[WIDTH-1:0];
                c_next = add_ext[WIDTH];
                v_next = add_ovf;
            end
            OP_SUB: begin
                y_next = sub_ext[WIDTH-1:0];
                c_next = sub_ext[WIDTH];
                v_next = sub_ovf;
            end
            OP_SHL: begin
                y_next = shl_ext[WIDTH-1:0];
                c_next = shl_ext[WIDTH];
            end
            OP_SHR: begin
                y_next = shr_ext[WIDTH:1];
                c_next = shr_ext[0];
            end
            default: y_next = '0;
        endcase
`ifdef ALU_PIPE_SAT_EN
        // Overflow direction follows the sign of a for both ADD and SUB
        if (((op_e == OP_ADD) || (op_e == OP_SUB)) && v_next) begin
            y_next = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        flags         = '0;
        flags[FLAG_N] = y_next[WIDTH-1];
        flags[FLAG_Z] = (y_next == '0);
        flags[FLAG_C] = c_next;
        flags[FLAG_V] = v_next;
    end

    assign y = y_next;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline. Stage 1 holds op/a/b, stage 2 holds
// y/flags; alu_core sits between them. Accept-to-out_valid latency is two
// cycles with full throughput when out_ready stays high.
// Optional feature: ALU_PIPE_SAT_EN (saturating ADD/SUB, handled in alu_core).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    if (!width_is_legal(WIDTH)) begin : g_bad_width
        $error("alu_pipe: WIDTH must be 4, 8, 16 or 32");
    end

    logic             s1_valid_reg;
    logic [2:0]       s1_op_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic             s2_valid_reg;
    logic [WIDTH-1:0] s2_y_reg;
    logic [3:0]       s2_flags_reg;
    logic             s2_ready;
    logic [WIDTH-1:0] core_y;
    logic [3:0]       core_flags;

    // Stage 2 can take new content when empty or its beat leaves this cycle;
    // stage 1 frees up whenever stage 2 can take its beat.
    assign s2_ready = !s2_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || s2_ready;

    // Stage 1: capture operands on an accepted beat, drop valid when it moves on
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_op_reg <= op;
                s1_a_reg  <= a;
                s1_b_reg  <= b;
            end
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op    (s1_op_reg),
        .a     (s1_a_reg),
        .b     (s1_b_reg),
        .y     (core_y),
        .flags (core_flags)
    );

    // Stage 2: register result and flags; held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_y_reg     <= '0;
            s2_flags_reg <= '0;
        end else if (s2_ready) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_y_reg     <= core_y;
                s2_flags_reg <= core_flags;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign y         = s2_y_reg;
    assign flags     = s2_flags_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=4: directed vectors, back-to-back
// throughput, stall/hold behaviour, mid-flight reset and random traffic.
module tb_alu_pipe;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [3:0]       flags;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [WIDTH+3:0] sb_q[$];
    int               acc_cyc_q[$];
    int               out_cyc_q[$];
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] held_y;
    logic [3:0]       held_flags;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
        end
    endtask

    // Reference model: arithmetic done on wide integers, packed as {y, N, Z, C, V}
    function automatic logic [WIDTH+3:0] model(input logic [2:0] o,
                                               input logic [WIDTH-1:0] aa,
                                               input logic [WIDTH-1:0] bb);
        longint ua, ub, sav, sbv, r, sr, smax, smin;
        int n;
        logic [WIDTH-1:0] yy;
        logic c, v;
        ua   = longint'(aa);
        ub   = longint'(bb);
        sav  = aa[WIDTH-1] ? ua - (longint'(1) << WIDTH) : ua;
        sbv  = bb[WIDTH-1] ? ub - (longint'(1) << WIDTH) : ub;
        smax = (longint'(1) << (WIDTH-1)) - 1;
        smin = -(longint'(1) << (WIDTH-1));
        n    = int'(ub % WIDTH);
        c = 1'b0; v = 1'b0; r = 0; sr = 0;
        case (o)
            3'd0: r = ua & ub;
            3'd1: r = ua | ub;
            3'd2: r = ua ^ ub;
            3'd3: r = ~ua;
            3'd4: begin r = ua + ub; c = r[WIDTH]; sr = sav + sbv; v = (sr > smax) || (sr < smin); end
            3'd5: begin r = ua - ub; c = (ua < ub); sr = sav - sbv; v = (sr > smax) || (sr < smin); end
            3'd6: begin r = ua << n; if (n != 0) c = aa[WIDTH-n]; end
            default: begin r = ua >> n; if (n != 0) c = aa[n-1]; end
        endcase
        yy = r[WIDTH-1:0];
`ifdef ALU_PIPE_SAT_EN
        if (((o == 3'd4) || (o == 3'd5)) && v) yy = (sr > smax) ? smax[WIDTH-1:0] : smin[WIDTH-1:0];
`endif
        return {yy, yy[WIDTH-1], (yy == '0), c, v};
    endfunction

    // Present one beat (called #1 after a rising edge); push expectation on acceptance
    task automatic drive(input logic [2:0] o, input logic [WIDTH-1:0] aa,
                         input logic [WIDTH-1:0] bb, input logic [WIDTH+3:0] e);
        logic ok;
        in_valid = 1'b1; op = o; a = aa; b = bb;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check_eq("accept_timeout", {31'b0, ok}, 1);
        else begin
            sb_q.push_back(e);
            acc_cyc_q.push_back(cyc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        check_eq("drain_empty", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Output monitor: hold check while stalled, scoreboard compare on transfer
    initial forever begin
        logic [WIDTH+3:0] e;
        @(negedge clk);
        if (rst_n) begin
            if (stall_prev) begin
                check_eq("hold_y", y, held_y);
                check_eq("hold_flags", flags, held_flags);
            end
            if (out_valid && out_ready) begin
                out_cyc_q.push_back(cyc);
                if (sb_q.size() == 0) check_eq("unexpected_out", {31'b0, out_valid}, 0);
                else begin
                    e = sb_q.pop_front();
                    check_eq("y", y, e[WIDTH+3:4]);
                    check_eq("flags", flags, e[3:0]);
                end
            end
            stall_prev = out_valid && !out_ready;
            held_y     = y;
            held_flags = flags;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        logic rand_done;
        int   accepted;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", {31'b0, out_valid}, 0);
        check_eq("rst_y", y, 0);
        check_eq("rst_flags", flags, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1;

        // Directed vectors with hand-derived expectations {y, N, Z, C, V}
`ifdef ALU_PIPE_SAT_EN
        drive(3'd4, 4'b0111, 4'b0001, {4'b0111, 4'b0001});
`else
        drive(3'd4, 4'b0111, 4'b0001, {4'b1000, 4'b1001});
`endif
        drive(3'd5, 4'b0000, 4'b0001, {4'b1111, 4'b1010});
        drive(3'd0, 4'b1010, 4'b1100, {4'b1000, 4'b1000});
        drive(3'd2, 4'b0101, 4'b0101, {4'b0000, 4'b0100});
        drive(3'd6, 4'b1001, 4'b0001, {4'b0010, 4'b0010});
        drive(3'd7, 4'b1001, 4'b0000, {4'b1001, 4'b1000});
        drive(3'd3, 4'b0110, 4'b0000, {4'b1001, 4'b1000});
        drive(3'd1, 4'b0000, 4'b0000, {4'b0000, 4'b0100});
        wait_drain();

        // Back-to-back 8 beats with out_ready high
        acc_cyc_q.delete();
        out_cyc_q.delete();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] o;
            logic [WIDTH-1:0] aa, bb;
            o  = 3'(i);
            aa = WIDTH'(i * 3 + 5);
            bb = WIDTH'(i + 1);
            drive(o, aa, bb, model(o, aa, bb));
        end
        wait_drain();
        check_eq("b2b_count", out_cyc_q.size(), 8);
        if (out_cyc_q.size() == 8 && acc_cyc_q.size() == 8) begin
            check_eq("b2b_latency", out_cyc_q[0] - acc_cyc_q[0], 2);
            check_eq("b2b_span", out_cyc_q[7] - out_cyc_q[0], 7);
            check_eq("b2b_accept_span", acc_cyc_q[7] - acc_cyc_q[0], 7);
        end

        // Stall: out_ready low for 4 cycles with in_valid held high
        out_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; op = 3'd4; a = WIDTH'(k + 1); b = WIDTH'(k + 6);
            @(negedge clk);
            if (k >= 2) check_eq("stall_in_ready", {31'b0, in_ready}, 0);
            if (in_ready) begin
                sb_q.push_back(model(op, a, b));
                accepted++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("stall_accepts", accepted, 2);
        out_ready = 1'b1;
        wait_drain();

        // Reset with both stages full
        out_ready = 1'b0;
        drive(3'd4, 4'b0011, 4'b0100, model(3'd4, 4'b0011, 4'b0100));
        drive(3'd2, 4'b1111, 4'b0001, model(3'd2, 4'b1111, 4'b0001));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check_eq("midrst_out_valid", {31'b0, out_valid}, 0);
        check_eq("midrst_y", y, 0);
        check_eq("midrst_flags", flags, 0);
        check_eq("midrst_in_ready", {31'b0, in_ready}, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("midrst_no_out", {31'b0, out_valid}, 0);
        end
        @(posedge clk); #1;
        drive(3'd5, 4'b1000, 4'b0001, model(3'd5, 4'b1000, 4'b0001));
        wait_drain();

        // Random traffic with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [2:0] o;
                    logic [WIDTH-1:0] aa, bb;
                    o  = 3'($urandom_range(0, 7));
                    aa = WIDTH'($urandom);
                    bb = WIDTH'($urandom);
                    drive(o, aa, bb, model(o, aa, bb));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
